nd_array_frame_collector: RTL and testbench

Receive-side counterpart of the nd-array permuting packer. It accepts a stream of WIDTH-bit elements in the packer's permuted beat and bit order, undoes both permutations, and assembles a complete ROWS x COLS array. The finished frame is presented as one flattened word with a valid/ready handshake. The block sits between the serial link from the packer and any consumer that needs the array in natural [row][col] order.

---
 rtl/nd_array_frame_collector_if.sv | 27 ++
 rtl/nd_array_frame_collector.sv | 95 +++++++++
 tb/tb_nd_array_frame_collector.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/nd_array_frame_collector_if.sv
// Element stream in, assembled frame out: handshake bundle for the frame collector.
interface nd_array_frame_collector_if #(
  parameter int unsigned ROWS  = 6,
  parameter int unsigned COLS  = 4,
  parameter int unsigned WIDTH = 3
);
  logic                        in_valid;
  logic                        in_ready;
  logic [WIDTH-1:0]            in_data;
  logic                        in_last;
  logic                        out_valid;
  logic                        out_ready;
  logic [ROWS*COLS*WIDTH-1:0]  out_data;
  logic                        err;

  // Driver side: the packer link plus the frame consumer.
  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, err
  );

  // Collector side.
  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, err
  );
endinterface

// File: rtl/nd_array_frame_collector.sv
// Undoes the packer's beat and bit permutations and assembles a ROWS x COLS frame,
// presented as one flattened word with a valid/ready handshake.
module nd_array_frame_collector #(
  parameter int unsigned ROWS       = 6,
  parameter int unsigned COLS       = 4,
  parameter int unsigned WIDTH      = 3,
  parameter int unsigned PLAIN_ROWS = 2
) (
  input  logic                      CLK,
  input  logic                      RESET,
  nd_array_frame_collector_if.slave bus
);
  localparam int unsigned N    = ROWS * COLS;
  localparam int unsigned FW   = N * WIDTH;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned POSW = $clog2(FW);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [FW-1:0]    buf_q, buf_d;
  logic [FW-1:0]    out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             err_q, err_d;

  logic             at_last_c;
  logic             accept_c;
  logic [WIDTH-1:0] orig_c;
  logic [POSW-1:0]  pos_c;

  assign at_last_c    = (cnt_q == CW'(N - 1));
  assign bus.in_ready = !at_last_c || !out_valid_q || bus.out_ready;
  assign accept_c     = bus.in_valid && bus.in_ready;

  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;

  // Beat position and bit unpermute for the current beat.
  always_comb begin
    int unsigned r;
    int unsigned j;
    int unsigned c;
    r      = 32'(cnt_q) / COLS;
    j      = 32'(cnt_q) % COLS;
    c      = (j == 0) ? 0 : COLS - j;
    pos_c  = POSW'((r * COLS + c) * WIDTH);
    orig_c = bus.in_data;
    if (r >= PLAIN_ROWS) begin
      for (int k = 1; k < int'(WIDTH); k++) begin
        orig_c[k] = bus.in_data[int'(WIDTH) - k];
      end
    end
  end

  // Next-state: collect, complete, or drop on a framing error.
  always_comb begin
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    err_d       = 1'b0;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    if (accept_c) begin
      if (bus.in_last && at_last_c) begin
        out_data_d                 = buf_q;
        out_data_d[pos_c +: WIDTH] = orig_c;
        out_valid_d                = 1'b1;
        cnt_d                      = '0;
      end else if (bus.in_last != at_last_c) begin
        cnt_d = '0;
        err_d = 1'b1;
      end else begin
        buf_d[pos_c +: WIDTH] = orig_c;
        cnt_d                 = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q       <= '0;
      buf_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
    end
  end
endmodule

// File: tb/tb_nd_array_frame_collector.sv
// Directed bench for nd_array_frame_collector (6x4 frame, 3-bit elements, 2 plain rows).
module tb_nd_array_frame_collector;
  logic CLK = 1'b0;
  logic RESET;
  int   checks = 0;
  int   errors = 0;

  always #5 CLK = ~CLK;

  nd_array_frame_collector_if #(.ROWS(6), .COLS(4), .WIDTH(3)) bus ();

  nd_array_frame_collector #(.ROWS(6), .COLS(4), .WIDTH(3), .PLAIN_ROWS(2)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Natural element [r][c] = (r*4+c+off)%8; rows >= 2 go out as {o[1],o[2],o[0]}.
  function automatic logic [2:0] enc(input int cnt, input int off);
    int r, j, c;
    logic [2:0] o;
    r = cnt / 4;
    j = cnt % 4;
    c = (4 - j) % 4;
    o = 3'((r * 4 + c + off) % 8);
    if (r >= 2) return {o[1], o[2], o[0]};
    return o;
  endfunction

  function automatic logic [71:0] exp_word(input int off);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 24; i++) w[i*3 +: 3] = 3'((i + off) % 8);
    return w;
  endfunction

  task automatic send_beat(input logic [2:0] d, input logic l);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      @(posedge CLK); #1;
      t++;
    end
    if (t >= 50) check("in_ready_timeout", 72'(bus.in_ready), 72'(1));
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_beats(input int first, input int last_excl, input int off);
    for (int i = first; i < last_excl; i++) send_beat(enc(i, off), 1'b0);
  endtask

  task automatic send_frame(input int off);
    send_beats(0, 23, off);
    send_beat(enc(23, off), 1'b1);
  endtask

  initial begin
    logic [71:0] w;
    RESET         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Reset state
    check("rst_out_valid", 72'(bus.out_valid), 72'(0));
    check("rst_out_data", bus.out_data, 72'(0));
    check("rst_err", 72'(bus.err), 72'(0));
    check("rst_in_ready", 72'(bus.in_ready), 72'(1));

    // Single frame
    send_beats(0, 23, 0);
    check("f1_not_early", 72'(bus.out_valid), 72'(0));
    send_beat(enc(23, 0), 1'b1);
    check("f1_out_valid", 72'(bus.out_valid), 72'(1));
    check("f1_out_data", bus.out_data, exp_word(0));
    w = bus.out_data;
    check("f1_elem_2_2", 72'(w[32:30]), 72'(3'b010));
    check("f1_beat10_enc", 72'(enc(10, 0)), 72'(3'b100));
    @(posedge CLK); #1;
    check("f1_drained", 72'(bus.out_valid), 72'(0));

    // Backpressure: hold frame A, stream frame B which stalls on its last beat
    bus.out_ready = 1'b0;
    send_frame(0);
    check("bp_a_valid", 72'(bus.out_valid), 72'(1));
    send_beats(0, 22, 3);
    check("bp_ready_cnt22", 72'(bus.in_ready), 72'(1));
    send_beat(enc(22, 3), 1'b0);
    bus.in_valid = 1'b1;
    bus.in_data  = enc(23, 3);
    bus.in_last  = 1'b1;
    #1;
    check("bp_stall", 72'(bus.in_ready), 72'(0));
    repeat (2) @(posedge CLK);
    #1;
    check("bp_still_stalled", 72'(bus.in_ready), 72'(0));
    check("bp_a_held", bus.out_data, exp_word(0));
    bus.out_ready = 1'b1;
    #1;
    check("bp_release", 72'(bus.in_ready), 72'(1));
    @(posedge CLK); #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check("bp_b_valid", 72'(bus.out_valid), 72'(1));
    check("bp_b_data", bus.out_data, exp_word(3));
    w = bus.out_data;
    check("plain_elem_0_3", 72'(w[11:9]), 72'(3'b110));
    check("plain_beat1_enc", 72'(enc(1, 3)), 72'(3'b110));
    @(posedge CLK); #1;
    check("bp_b_drained", 72'(bus.out_valid), 72'(0));

    // Early in_last on beat 5
    send_beats(0, 5, 1);
    send_beat(enc(5, 1), 1'b1);
    check("early_err", 72'(bus.err), 72'(1));
    check("early_no_valid", 72'(bus.out_valid), 72'(0));
    @(posedge CLK); #1;
    check("early_err_pulse", 72'(bus.err), 72'(0));
    send_frame(5);
    check("early_next_valid", 72'(bus.out_valid), 72'(1));
    check("early_next_data", bus.out_data, exp_word(5));
    @(posedge CLK); #1;

    // Missing in_last on beat 23
    send_beats(0, 23, 6);
    send_beat(enc(23, 6), 1'b0);
    check("miss_err", 72'(bus.err), 72'(1));
    check("miss_no_valid", 72'(bus.out_valid), 72'(0));
    check("miss_data_kept", bus.out_data, exp_word(5));
    @(posedge CLK); #1;
    check("miss_err_pulse", 72'(bus.err), 72'(0));
    send_frame(2);
    check("miss_next_data", bus.out_data, exp_word(2));

    // Reset mid-frame with a held output
    bus.out_ready = 1'b0;
    @(posedge CLK); #1;
    send_beats(0, 13, 7);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("mrst_out_valid", 72'(bus.out_valid), 72'(0));
    check("mrst_out_data", bus.out_data, 72'(0));
    check("mrst_err", 72'(bus.err), 72'(0));
    bus.out_ready = 1'b1;
    send_frame(4);
    check("mrst_next_valid", 72'(bus.out_valid), 72'(1));
    check("mrst_next_data", bus.out_data, exp_word(4));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
